// File: rtl/nn_result_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nn_result_pkg
// Brief    : Shared logit-frame sizing, minimum logit value and requester states.
// Revision : 1.0
// ============================================================================
package nn_result_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_SIZE  = 10;
    localparam int DEFAULT_IDX_W = $clog2(DEFAULT_SIZE);

    localparam logic signed [DEFAULT_WIDTH-1:0] MIN_VAL = {1'b1, {(DEFAULT_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_REQ     = 2'd1,
        ST_WAIT    = 2'd2,
        ST_OUT     = 2'd3
    } req_state_t;

endpackage : nn_result_pkg
`default_nettype wire

// File: rtl/logit_regfile.sv
`default_nettype none
// ============================================================================
// Module   : logit_regfile
// Brief    : SIZE x WIDTH write-indexed logit buffer with flat and indexed reads.
// Revision : 1.0
// ============================================================================
module logit_regfile #(
    parameter int WIDTH = 16,
    parameter int SIZE  = 10,
    parameter int IDX_W = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [IDX_W-1:0]        wr_idx,
    input  logic [WIDTH-1:0]        wr_data,
    input  logic [IDX_W-1:0]        rd_idx,
    output logic [WIDTH-1:0]        rd_data,
    output logic [SIZE*WIDTH-1:0]   data_flat
);

    logic [WIDTH-1:0] r_mem [SIZE];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < SIZE; k++) begin
                r_mem[k] <= '0;
            end
        end else if (wr_en) begin
            for (int k = 0; k < SIZE; k++) begin
                if (wr_idx == IDX_W'(k)) begin
                    r_mem[k] <= wr_data;
                end
            end
        end
    end

    // Out-of-range indices read as zero.
    always_comb begin
        rd_data = '0;
        for (int k = 0; k < SIZE; k++) begin
            if (rd_idx == IDX_W'(k)) begin
                rd_data = r_mem[k];
            end
        end
    end

    generate
        for (genvar k = 0; k < SIZE; k++) begin : g_flat
            assign data_flat[k*WIDTH +: WIDTH] = r_mem[k];
        end
    endgenerate

endmodule : logit_regfile
`default_nettype wire

// File: rtl/logit_frame_requester.sv
`default_nettype none
// ============================================================================
// Module   : logit_frame_requester
// Brief    : Buffers a logit frame, runs the argmax start/ack/done handshake
//            and offers the winning index and score on a valid/ready port.
// Revision : 1.0
// ============================================================================
module logit_frame_requester
    import nn_result_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int SIZE        = DEFAULT_SIZE,
    parameter int IDX_W       = $clog2(SIZE),
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        in_data,
    input  logic                    in_last,
    output logic [SIZE*WIDTH-1:0]   data_flat,
    output logic                    am_start,
    input  logic                    am_ack,
    input  logic                    am_done,
    input  logic [IDX_W-1:0]        am_index,
    output logic                    cls_valid,
    input  logic                    cls_ready,
    output logic [IDX_W-1:0]        cls_index,
    output logic [WIDTH-1:0]        cls_score,
    output logic                    err
);

    localparam int               TO_W        = $clog2(ACK_TIMEOUT) + 1;
    localparam logic [IDX_W-1:0] C_LAST_IDX  = IDX_W'(SIZE - 1);
    localparam logic [TO_W-1:0]  C_LAST_TO   = TO_W'(ACK_TIMEOUT - 1);

    req_state_t       r_state;
    req_state_t       w_state_nxt;
    logic [IDX_W-1:0] r_cnt;
    logic [IDX_W-1:0] w_cnt_nxt;
    logic [TO_W-1:0]  r_tcnt;
    logic [TO_W-1:0]  w_tcnt_nxt;
    logic             w_am_start_nxt;
    logic             w_err_nxt;
    logic             w_wr_en;
    logic             w_cls_load;
    logic             w_cls_clear;
    logic [WIDTH-1:0] w_rd_data;

    logit_regfile #(
        .WIDTH (WIDTH),
        .SIZE  (SIZE),
        .IDX_W (IDX_W)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (w_wr_en),
        .wr_idx    (r_cnt),
        .wr_data   (in_data),
        .rd_idx    (am_index),
        .rd_data   (w_rd_data),
        .data_flat (data_flat)
    );

    assign in_ready = (r_state == ST_COLLECT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_COLLECT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_tcnt_nxt     = '0;
        w_am_start_nxt = 1'b0;
        w_err_nxt      = 1'b0;
        w_wr_en        = 1'b0;
        w_cls_load     = 1'b0;
        w_cls_clear    = 1'b0;
        case (r_state)
            ST_COLLECT: begin
                if (in_valid) begin
                    w_wr_en = 1'b1;
                    // A full frame is always scanned; a missing in_last is only flagged.
                    if (r_cnt == C_LAST_IDX) begin
                        w_cnt_nxt      = '0;
                        w_am_start_nxt = 1'b1;
                        w_err_nxt      = ~in_last;
                        w_state_nxt    = ST_REQ;
                    end else if (in_last) begin
                        w_cnt_nxt = '0;
                        w_err_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            ST_REQ: begin
                w_am_start_nxt = 1'b1;
                if (am_ack) begin
                    w_am_start_nxt = 1'b0;
                    w_state_nxt    = ST_WAIT;
                end else if (r_tcnt == C_LAST_TO) begin
                    w_am_start_nxt = 1'b0;
                    w_err_nxt      = 1'b1;
                    w_state_nxt    = ST_COLLECT;
                end else begin
                    w_tcnt_nxt = r_tcnt + 1'b1;
                end
            end
            ST_WAIT: begin
                if (am_done) begin
                    w_cls_load  = 1'b1;
                    w_state_nxt = ST_OUT;
                end
            end
            ST_OUT: begin
                if (cls_ready) begin
                    w_cls_clear = 1'b1;
                    w_state_nxt = ST_COLLECT;
                end
            end
            default: begin
                w_state_nxt = ST_COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_tcnt    <= '0;
            am_start  <= 1'b0;
            err       <= 1'b0;
            cls_valid <= 1'b0;
            cls_index <= '0;
            cls_score <= '0;
        end else begin
            r_cnt    <= w_cnt_nxt;
            r_tcnt   <= w_tcnt_nxt;
            am_start <= w_am_start_nxt;
            err      <= w_err_nxt;
            if (w_cls_load) begin
                cls_valid <= 1'b1;
                cls_index <= am_index;
                cls_score <= w_rd_data;
            end else if (w_cls_clear) begin
                cls_valid <= 1'b0;
            end
        end
    end

endmodule : logit_frame_requester
`default_nettype wire

// File: tb/tb_logit_frame_requester.sv
`default_nettype none
// ============================================================================
// Module   : tb_logit_frame_requester
// Brief    : Scoreboard bench with a behavioural argmax responder.
// Revision : 1.0
// ============================================================================
module tb_logit_frame_requester;
    import nn_result_pkg::*;

    localparam int WIDTH = 16;
    localparam int SIZE  = 10;
    localparam int IDX_W = 4;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic [WIDTH-1:0]      in_data = '0;
    logic                  in_last = 1'b0;
    logic [SIZE*WIDTH-1:0] data_flat;
    logic                  am_start;
    logic                  am_ack = 1'b0;
    logic                  am_done = 1'b0;
    logic [IDX_W-1:0]      am_index = '0;
    logic                  cls_valid;
    logic                  cls_ready = 1'b1;
    logic [IDX_W-1:0]      cls_index;
    logic [WIDTH-1:0]      cls_score;
    logic                  err;

    logit_frame_requester #(
        .WIDTH(WIDTH), .SIZE(SIZE), .IDX_W(IDX_W), .ACK_TIMEOUT(16)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .data_flat(data_flat),
        .am_start(am_start), .am_ack(am_ack), .am_done(am_done),
        .am_index(am_index), .cls_valid(cls_valid), .cls_ready(cls_ready),
        .cls_index(cls_index), .cls_score(cls_score), .err(err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [WIDTH-1:0] score;
    } exp_t;
    exp_t exp_q[$];

    logic signed [WIDTH-1:0] fr [SIZE];

    // Responder / monitor state
    logic ack_en      = 1'b1;
    logic skip_stab   = 1'b0;
    int   done_delay  = 3;
    int   starts      = 0;
    int   err_count   = 0;
    int   err_run     = 0;
    int   err_maxrun  = 0;
    int   st_run      = 0;
    int   st_lastrun  = 0;
    int   valid_cyc   = 0;
    logic prev_start  = 1'b0;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Scoreboard monitor: compare each accepted result against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && cls_valid && cls_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("cls_index", cls_index, e.idx);
                    chk("cls_score", $signed(cls_score), $signed(e.score));
                end
            end
        end
    end

    // Event counters sampled away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (am_start && !prev_start) starts++;
            prev_start = am_start;
            if (am_start) st_run++;
            else if (st_run > 0) begin st_lastrun = st_run; st_run = 0; end
            if (err) begin
                err_run++;
                if (err_run == 1) err_count++;
                if (err_run > err_maxrun) err_maxrun = err_run;
            end else begin
                err_run = 0;
            end
            if (cls_valid) valid_cyc++;
        end
    end

    // Behavioural argmax engine: lowest index wins on ties.
    initial begin
        logic [SIZE*WIDTH-1:0] snap;
        logic signed [WIDTH-1:0] best;
        logic signed [WIDTH-1:0] v;
        int bi;
        forever begin
            @(negedge clk);
            if (am_start && ack_en && !rst) begin
                snap = data_flat;
                @(posedge clk); #1 am_ack = 1'b1;
                @(posedge clk); #1 am_ack = 1'b0;
                best = MIN_VAL;
                bi = 0;
                for (int k = 0; k < SIZE; k++) begin
                    v = snap[k*WIDTH +: WIDTH];
                    if (v > best || k == 0) begin best = v; bi = k; end
                end
                repeat (done_delay) @(posedge clk);
                #1;
                if (!skip_stab) chk("flat_stable", (data_flat == snap) ? 1 : 0, 1);
                am_done = 1'b1;
                am_index = IDX_W'(bi);
                @(posedge clk); #1 am_done = 1'b0;
            end
        end
    end

    task automatic send(input int n, input int last_at);
        int guard;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = fr[i];
            in_last  = (i == last_at);
            guard = 0;
            @(negedge clk);
            while (!in_ready && guard < 200) begin
                guard++;
                @(negedge clk);
            end
            if (guard >= 200) chk("in_ready_timeout", 0, 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic push(input int idx, input int score);
        exp_t e;
        e.idx   = IDX_W'(idx);
        e.score = WIDTH'(score);
        exp_q.push_back(e);
    endtask

    task automatic drain;
        int guard = 0;
        while (exp_q.size() != 0 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        chk("drain_queue", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic set_frame(input int a0, a1, a2, a3, a4, a5, a6, a7, a8, a9);
        fr[0] = WIDTH'(a0); fr[1] = WIDTH'(a1); fr[2] = WIDTH'(a2); fr[3] = WIDTH'(a3);
        fr[4] = WIDTH'(a4); fr[5] = WIDTH'(a5); fr[6] = WIDTH'(a6); fr[7] = WIDTH'(a7);
        fr[8] = WIDTH'(a8); fr[9] = WIDTH'(a9);
    endtask

    initial begin
        int guard;
        int bad;
        logic [IDX_W-1:0] hold_idx;
        logic [WIDTH-1:0] hold_score;
        int s0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_am_start", am_start, 0);
        chk("rst_cls_valid", cls_valid, 0);
        chk("rst_err", err, 0);
        chk("rst_data_flat_zero", (data_flat == '0) ? 1 : 0, 1);
        @(posedge clk); #1;

        // Ties resolve to the lowest index.
        set_frame(3, -5, 7, 2, 0, 7, -1, 1, 4, 6);
        push(2, 7);
        send(10, 9);
        drain();
        chk("starts_frame1", starts, 1);

        set_frame(-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32767);
        push(9, -32767);
        send(10, 9);
        drain();
        chk("no_err_good_frames", err_count, 0);

        // Short frame is dropped with a single-cycle err.
        set_frame(1, 2, 3, 4, 0, 0, 0, 0, 0, 0);
        s0 = starts;
        send(4, 3);
        repeat (4) @(posedge clk);
        #1;
        chk("short_err_count", err_count, 1);
        chk("short_err_width", err_maxrun, 1);
        chk("short_no_start", starts, s0);
        set_frame(0, 0, 0, 0, 0, 0, 0, 0, 50, 0);
        push(8, 50);
        send(10, 9);
        drain();

        // Backpressure on the result port.
        cls_ready = 1'b0;
        set_frame(1, 2, 3, 4, 5, 6, 7, 8, 9, -1);
        push(8, 9);
        send(10, 9);
        guard = 0;
        @(negedge clk);
        while (!cls_valid && guard < 200) begin guard++; @(negedge clk); end
        chk("bp_valid_seen", cls_valid, 1);
        hold_idx = cls_index;
        hold_score = cls_score;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (!cls_valid || cls_index != hold_idx || cls_score != hold_score || in_ready) bad++;
            @(negedge clk);
        end
        chk("bp_stable_20", bad, 0);
        @(posedge clk); #1 cls_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_valid_cleared", cls_valid, 0);
        chk("bp_in_ready_back", in_ready, 1);
        drain();

        // Ack timeout.
        ack_en = 1'b0;
        s0 = err_count;
        set_frame(5, 4, 3, 2, 1, 0, -1, -2, -3, -4);
        send(10, 9);
        guard = 0;
        @(negedge clk);
        while ((am_start || st_lastrun == 0 || st_run != 0) && guard < 100) begin
            guard++;
            @(negedge clk);
        end
        @(negedge clk);
        chk("timeout_start_width", st_lastrun, 16);
        chk("timeout_err", err_count, s0 + 1);
        chk("timeout_in_ready", in_ready, 1);
        ack_en = 1'b1;
        @(posedge clk); #1;
        push(0, 5);
        send(10, 9);
        drain();

        // Reset while waiting for am_done; the late done must be ignored.
        done_delay = 10;
        skip_stab = 1'b1;
        set_frame(1, 1, 1, 1, 1, 1, 1, 1, 1, 99);
        s0 = starts;
        send(10, 9);
        guard = 0;
        while (!am_ack && guard < 100) begin guard++; @(negedge clk); end
        @(posedge clk); #1;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("wrst_am_start", am_start, 0);
        chk("wrst_cls_index", cls_index, 0);
        chk("wrst_cls_score", cls_score, 0);
        chk("wrst_data_flat", (data_flat == '0) ? 1 : 0, 1);
        chk("wrst_in_ready", in_ready, 1);
        valid_cyc = 0;
        guard = 0;
        while (!am_done && guard < 50) begin guard++; @(negedge clk); end
        repeat (4) @(negedge clk);
        chk("wrst_no_valid", valid_cyc, 0);
        done_delay = 3;
        skip_stab = 1'b0;
        @(posedge clk); #1;
        set_frame(-7, -3, -9, -3, -8, -4, -5, -6, -10, -11);
        push(1, -3);
        send(10, 9);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule : tb_logit_frame_requester
`default_nettype wire

// File: doc/logit_frame_requester.md
Name: logit_frame_requester

Overview:
- Initiator side of the argmax start/ack/done handshake.
- Collects one frame of SIZE signed final-layer logits from the output-layer MAC stream into a flat register buffer and presents it as data_flat.
- Requests a scan from the argmax engine, captures the returned index plus its score, and offers both downstream on a valid/ready port.
- Sits between the last dense layer and the classification result interface.

Parameters:
- WIDTH, 16, bits per signed logit.
- SIZE, 10, logits per frame (number of classes).
- IDX_W, $clog2(SIZE), class index width.
- ACK_TIMEOUT, 16, max cycles in REQ waiting for am_ack before abort.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  logit stream valid.
- in_ready  out  1  logit stream ready.
- in_data  in  WIDTH  signed logit.
- in_last  in  1  marks final logit of frame.
- data_flat  out  SIZE*WIDTH  buffered frame; element k at [k*WIDTH +: WIDTH].
- am_start  out  1  scan request to argmax.
- am_ack  in  1  argmax accepted request.
- am_done  in  1  one-cycle pulse; am_index valid.
- am_index  in  IDX_W  winning class from argmax.
- cls_valid  out  1  result valid.
- cls_ready  in  1  result accepted.
- cls_index  out  IDX_W  winning class.
- cls_score  out  WIDTH  signed logit of winning class.
- err  out  1  one-cycle pulse on framing error or ack timeout.

Behaviour:
- Reset (synchronous, active-high, clk edge) sets:
  - state=COLLECT, cnt=0, buffer/data_flat=0.
  - am_start=0, cls_valid=0, cls_index=0, cls_score=0, err=0, timeout counter=0.
- Reset mid-operation aborts any frame; am_done arriving after reset is ignored.
- All outputs are registered except in_ready, which equals (state==COLLECT).
- err defaults to 0 every cycle unless set below.
- COLLECT:
  - On in_valid&&in_ready, buffer[cnt]<=in_data and cnt++.
  - in_last with cnt<SIZE-1: frame dropped, cnt<=0, err pulse, stay COLLECT.
  - Handshake at cnt==SIZE-1: element stored, cnt<=0, am_start<=1, go REQ.
    - If in_last=0 on this element, also pulse err; the frame is still processed.
- REQ:
  - am_start held 1.
  - On am_ack=1: am_start<=0 (drops the cycle after ack is seen), go WAIT.
  - Timeout counter increments each REQ cycle. On reaching ACK_TIMEOUT without ack: am_start<=0, err pulse, go COLLECT.
  - The timeout counter clears on leaving REQ.
- WAIT:
  - am_start=0.
  - On am_done: cls_index<=am_index, cls_score<=buffer[am_index] (0 if am_index>=SIZE), cls_valid<=1, go OUT.
  - No timeout in WAIT, because argmax latency is bounded.
- OUT:
  - cls_valid/cls_index/cls_score held stable until cls_ready.
  - On cls_valid&&cls_ready: cls_valid<=0, go COLLECT. in_ready is 1 the following cycle.
- data_flat is never written outside COLLECT, so it is stable from am_start rise through am_done as argmax requires.
- am_ack/am_done seen outside REQ/WAIT respectively are ignored.
- Tie-breaking is owned by argmax (lowest index wins); this block does not alter the returned index.
- Minimum per-frame overhead after the last logit is REQ(>=1) + argmax scan + WAIT→OUT(1) + OUT(>=1) cycles.

Decomposition:
- Shared package nn_result_pkg holds:
  - WIDTH, SIZE, IDX_W defaults.
  - MIN_VAL constant.
  - State enum {COLLECT, REQ, WAIT, OUT}.
- One natural sub-module: logit_regfile. It provides the SIZE×WIDTH write-indexed buffer with flat read-out and an indexed read port for cls_score.

Test Plan:
- Frame [3,-5,7,2,0,7,-1,1,4,6] with in_last on the 10th element, behavioural argmax model -> one am_start, then cls_index=2, cls_score=7, err never set.
- Frame all -32768 except index 9 = -32767 -> cls_index=9, cls_score=-32767; data_flat unchanged between am_start rise and am_done.
- in_last on the 4th element -> err pulse exactly 1 cycle, no am_start; the following full frame [0,0,0,0,0,0,0,0,50,0] -> cls_index=8, cls_score=50.
- cls_ready held 0 for 20 cycles after cls_valid -> cls_valid/index/score stable and in_ready=0 throughout; on cls_ready=1 -> cls_valid=0 and in_ready=1 next cycle.
- am_ack never asserted, ACK_TIMEOUT=16 -> am_start high 16 cycles then 0, err pulse, back in COLLECT accepting data.
- rst pulsed during WAIT, then am_done arrives -> all outputs at reset values, cls_valid stays 0, next frame processed normally.
